// File: rtl/instr_prefetch.sv
// Instruction prefetch: owns the fetch PC, issues 1-cycle imem reads and queues {pc, instr} for decode.
// Optional IFETCH_STATS_EN adds fetch_count / flush_count statistics ports.
`timescale 1ns/1ps
module instr_prefetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halt
`ifdef IFETCH_STATS_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [7:0]        flush_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_STOP = 2'd1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_pending;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_mem_instr [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc    [DEPTH];

  logic              w_empty;
  logic [CW:0]       w_credit;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_halt_op;

  // Credit check counts the in-flight response so a request always has a slot waiting.
  assign w_empty   = (r_count == '0);
  assign w_credit  = {1'b0, r_count} + {{CW{1'b0}}, r_pending};
  assign w_issue   = rst_n & (r_state == S_RUN) & ~redirect & (w_credit < (CW+1)'(DEPTH));
  assign w_push    = r_pending & ~redirect;
  assign w_pop     = instr_valid & instr_ready;
  assign w_halt_op = (imem_data == '0);

  assign imem_req    = w_issue;
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = ~w_empty & ~redirect;
  assign instr       = w_empty ? '0 : r_mem_instr[r_rd_ptr];
  assign instr_pc    = w_empty ? '0 : r_mem_pc[r_rd_ptr];
  assign halt        = instr_valid & (instr == '0);

  // Queue storage: payload only, occupancy is tracked by the control registers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_data;
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_fetch_pc <= RESET_PC;
      r_pending  <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_state    <= S_RUN;
      r_fetch_pc <= redirect_pc;
      r_pending  <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_halt_op) r_state <= S_STOP;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IFETCH_STATS_EN
  logic [15:0] r_fetch_count;
  logic [7:0]  r_flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_push) r_fetch_count <= r_fetch_count + 16'd1;
      if (redirect && (!w_empty || r_pending) && (r_flush_count != 8'hFF))
        r_flush_count <= r_flush_count + 8'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif

endmodule
